strip_routing_header: RTL and testbench
=======================================

// Module: strip_routing_header
// PURPOSE
//  Downstream consumer of the routing-header inserter on the 36-bit FIFO stream. Parses the
//  routing header word and steers the packet to one of NUM_PORTS outputs. With STRIP=1 it
//  removes the header and sets SOF on the next word. Invalid packets are dropped to EOF.
//  Sits between the ingress FIFO and the per-destination FIFOs (DSP/CPU/ext).
// PARAMETERS
//  NUM_PORTS  2  number of output ports, 1..4
//  STRIP      1  1: drop header word, force SOF on next word; 0: forward header unchanged
// PORTS
//  clk        in   1            clock
//  reset      in   1            synchronous, active-high reset
//  clear      in   1            synchronous clear, same effect as reset
//  data_i     in   36           {occ[35:34], eof[33], sof[32], data[31:0]}
//  src_rdy_i  in   1            input word valid
//  dst_rdy_o  out  1            input word accepted when src_rdy_i&dst_rdy_o
//  data_o     out  36*NUM_PORTS port p occupies [36p+35:36p]
//  src_rdy_o  out  NUM_PORTS    per-port valid
//  dst_rdy_i  in   NUM_PORTS    per-port ready
//  err_o      out  1            one-cycle pulse: header invalid or length mismatch
//  drop_cnt   out  16           packets dropped, saturates at 16'hFFFF
// BEHAVIOUR
//  Header word: [32]=SOF=1, [33]=EOF=0, [31:17]=port_sel, [16]=1, [15:0]=payload bytes after header.
//  Header is valid iff SOF=1, EOF=0, bit16=1, port_sel<NUM_PORTS.
//  FSM states: HDR, ROUTE, DROP. Reset/clear: state=HDR, sel=0, word cnt=0, drop_cnt=0, err_o=0.
//  Reset/clear are synchronous, take priority over all transfers, and abort any packet in flight
//    (remainder is treated as new input).
//  HDR (dst_rdy_o=1, src_rdy_o=0):
//    - on input transfer, if header valid: latch sel=port_sel, exp=data_i[15:2], cnt=0.
//      STRIP=1 -> ROUTE, header consumed, never output.
//      STRIP=0 -> header is presented on port sel combinationally; ROUTE only once that
//      word transfers (dst_rdy_o=dst_rdy_i[sel] for this word).
//    - invalid header: err_o=1 next cycle, drop_cnt++.
//      If EOF=0 -> DROP; if EOF=1 -> stay HDR.
//  ROUTE: port sel data_o=data_i, except STRIP=1 and cnt==0 forces bit32=1.
//    - src_rdy_o[sel]=src_rdy_i; other ports src_rdy_o=0, data_o=0.
//    - dst_rdy_o=dst_rdy_i[sel]; zero-latency combinational path, no buffering.
//    - Each transfer increments cnt (14 bit, wraps).
//    - On EOF transfer -> HDR; if cnt+1 != exp then err_o=1 next cycle.
//      The packet is still delivered and drop_cnt is unchanged.
//    - SOF seen mid-packet is forwarded as data; not an error.
//  DROP: dst_rdy_o=1, all src_rdy_o=0; consume until EOF transfer, then HDR.
//  Stalls: src_rdy_i=0 or dst_rdy_i[sel]=0 holds all state; no words lost or duplicated.
//  Back-to-back packets: header may be accepted the cycle after the previous EOF transfer
//    (1 idle output cycle per packet with STRIP=1).
//  drop_cnt saturates at 16'hFFFF; err_o is never asserted twice for one packet.
// TESTING
//  1. NUM_PORTS=2, STRIP=1: hdr {0001,port=1,1,len=16'd12}, 3 words (last EOF)
//     -> port1 gets 3 words, first has bit32=1; port0 src_rdy stays 0; err_o=0.
//  2. Same packet, port1 dst_rdy_i toggled 1/0 each cycle, src_rdy_i random
//     -> identical 3-word output, order kept, no duplicates.
//  3. Header port_sel=3, NUM_PORTS=2, 5-word packet
//     -> dst_rdy_o=1 throughout, no output, err_o one pulse, drop_cnt=1, next packet routed.
//  4. Header len=16'd8 but 4 payload words
//     -> all 4 words delivered to sel port, err_o pulse after EOF, drop_cnt=0.
//  5. STRIP=0: 2-word packet to port0 -> port0 sees header word unchanged, then payload.
//  6. Assert reset in ROUTE mid-packet -> next cycle state HDR, all src_rdy_o=0,
//     dst_rdy_o=1, drop_cnt=0.

Source files
------------

// File: rtl/strip_routing_header.sv
// Routing-header parser and steering stage for the 36-bit FIFO stream.
// A header word selects one of NUM_PORTS outputs; the packet body is then
// passed straight through to that port with no buffering. Invalid headers
// cause the rest of the packet to be discarded up to EOF.
module strip_routing_header #(
    parameter int NUM_PORTS = 2,
    parameter int STRIP     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [35:0]             data_i,
    input  logic                    src_rdy_i,
    output logic                    dst_rdy_o,
    output logic [36*NUM_PORTS-1:0] data_o,
    output logic [NUM_PORTS-1:0]    src_rdy_o,
    input  logic [NUM_PORTS-1:0]    dst_rdy_i,
    output logic                    err_o,
    output logic [15:0]             drop_cnt
);

    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [13:0]        exp_q, exp_d;
    logic [13:0]        cnt_q, cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               err_q, err_d;

    logic               sync_rst;
    logic               hdr_valid;
    logic [SEL_W-1:0]   hdr_sel;
    logic               in_sof;
    logic               in_eof;
    logic               xfer;

    // Output steering: which port (if any) is driven this cycle and with what word
    logic               out_en;
    logic [SEL_W-1:0]   out_sel;
    logic [35:0]        out_word;
    logic               sel_rdy;
    logic               dst_rdy;
    logic [NUM_PORTS-1:0] port_hit;

    assign sync_rst  = reset | clear;
    assign in_sof    = data_i[32];
    assign in_eof    = data_i[33];
    // port_sel is range-checked, so its low bits are a complete port index
    assign hdr_valid = in_sof && !in_eof && data_i[16] &&
                       (data_i[31:17] < 15'(NUM_PORTS));
    assign hdr_sel   = data_i[17 +: SEL_W];
    assign xfer      = src_rdy_i && dst_rdy;

    // Datapath steering and upstream ready, combinational from current state
    always_comb begin
        out_en   = 1'b0;
        out_sel  = sel_q;
        out_word = data_i;
        sel_rdy  = 1'b0;
        dst_rdy  = 1'b1;
        case (state_q)
            ST_HDR: begin
                // Without stripping, the header itself is the first word out
                if (STRIP == 0 && hdr_valid) begin
                    out_en  = 1'b1;
                    out_sel = hdr_sel;
                end
            end
            ST_ROUTE: begin
                out_en  = 1'b1;
                out_sel = sel_q;
                // The stripped header carried the SOF; move it to the first payload word
                if (STRIP != 0 && cnt_q == 14'd0) begin
                    out_word[32] = 1'b1;
                end
            end
            default: begin
                out_en = 1'b0;
            end
        endcase
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (out_sel == SEL_W'(p)) begin
                sel_rdy = dst_rdy_i[p];
            end
        end
        if (out_en) begin
            dst_rdy = sel_rdy;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_hit[gi]         = out_en && (out_sel == SEL_W'(gi));
            assign src_rdy_o[gi]        = port_hit[gi] && src_rdy_i;
            assign data_o[36*gi +: 36]  = port_hit[gi] ? out_word : 36'd0;
        end
    endgenerate

    // Next-state, packet bookkeeping and error/drop accounting
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    if (hdr_valid) begin
                        sel_d   = hdr_sel;
                        exp_d   = data_i[15:2];
                        cnt_d   = 14'd0;
                        state_d = ST_ROUTE;
                    end else begin
                        err_d = 1'b1;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                        // A one-word bad packet is already fully consumed
                        state_d = in_eof ? ST_HDR : ST_DROP;
                    end
                end
            end
            ST_ROUTE: begin
                if (xfer) begin
                    cnt_d = cnt_q + 14'd1;
                    if (in_eof) begin
                        state_d = ST_HDR;
                        // Length mismatch is flagged but the packet is still delivered
                        if (cnt_q + 14'd1 != exp_q) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (xfer && in_eof) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // State registers; reset and clear abort any packet in flight
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= ST_HDR;
            sel_q      <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    assign dst_rdy_o = dst_rdy;
    assign err_o     = err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_strip_routing_header.sv
// Directed bench for strip_routing_header: instance 0 strips headers,
// instance 1 forwards them. Expected output words go into a per-instance
// scoreboard queue when driven and are matched as the DUT emits them.
module tb_strip_routing_header;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear;
    logic [35:0] din    [2];
    logic        src_i  [2];
    logic        dst_o  [2];
    logic [71:0] dout   [2];
    logic [1:0]  src_o  [2];
    logic [1:0]  dst_i  [2];
    logic        err    [2];
    logic [15:0] dcnt   [2];

    strip_routing_header #(.NUM_PORTS(2), .STRIP(1)) dut_strip (
        .clk(clk), .reset(reset), .clear(clear),
        .data_i(din[0]), .src_rdy_i(src_i[0]), .dst_rdy_o(dst_o[0]),
        .data_o(dout[0]), .src_rdy_o(src_o[0]), .dst_rdy_i(dst_i[0]),
        .err_o(err[0]), .drop_cnt(dcnt[0])
    );

    strip_routing_header #(.NUM_PORTS(2), .STRIP(0)) dut_fwd (
        .clk(clk), .reset(reset), .clear(clear),
        .data_i(din[1]), .src_rdy_i(src_i[1]), .dst_rdy_o(dst_o[1]),
        .data_o(dout[1]), .src_rdy_o(src_o[1]), .dst_rdy_i(dst_i[1]),
        .err_o(err[1]), .drop_cnt(dcnt[1])
    );

    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    int          err_seen [2];
    logic [37:0] sbq0 [$];
    logic [37:0] sbq1 [$];
    logic [35:0] pkt [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [35:0] mk_hdr(input int port, input int len);
        logic [14:0] ps;
        logic [15:0] ln;
        ps = 15'(port);
        ln = 16'(len);
        return {2'b00, 1'b0, 1'b1, ps, 1'b1, ln};
    endfunction

    function automatic logic [35:0] mk_word(input logic [31:0] d, input logic eof);
        return {2'b00, eof, 1'b0, d};
    endfunction

    // Output monitor: every accepted output word must match the scoreboard head
    always @(negedge clk) begin
        logic [37:0] got;
        logic [37:0] expw;
        logic [1:0]  pp;
        for (int inst = 0; inst < 2; inst++) begin
            if (err[inst] === 1'b1) err_seen[inst]++;
            for (int p = 0; p < 2; p++) begin
                if (src_o[inst][p] && dst_i[inst][p]) begin
                    pp   = 2'(p);
                    got  = {pp, dout[inst][36*p +: 36]};
                    expw = {2'b11, 36'd0};
                    if (inst == 0 && sbq0.size() > 0) expw = sbq0.pop_front();
                    if (inst == 1 && sbq1.size() > 0) expw = sbq1.pop_front();
                    chk($sformatf("out_word_i%0d", inst), 64'(got), 64'(expw));
                    $display("out inst=%0d port=%0d word=%h", inst, p, got[35:0]);
                end
            end
        end
    end

    // Drive pkt[0..n-1] into one instance; expected outputs are queued as each word is first presented
    task automatic send_pkt(input int inst, input int n, input int rnd_src, input int dst_mode,
                            input int exp_port, output int cycles);
        int          i = 0;
        int          cyc = 0;
        int          last = -1;
        logic        tg = 1'b0;
        logic [35:0] w;
        logic [1:0]  ep;
        ep = 2'(exp_port);
        while (i < n && cyc < 400) begin
            @(posedge clk); #1;
            din[inst]   = pkt[i];
            src_i[inst] = (rnd_src != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            tg          = ~tg;
            dst_i[inst] = (dst_mode == 0) ? 2'b11 : (dst_mode == 1) ? {tg, tg} : 2'b00;
            if (i != last) begin
                last = i;
                if (exp_port >= 0) begin
                    w = pkt[i];
                    if (inst == 0) begin
                        if (i == 1) w[32] = 1'b1;
                        if (i > 0) sbq0.push_back({ep, w});
                    end else begin
                        sbq1.push_back({ep, w});
                    end
                end
            end
            @(negedge clk);
            if (src_i[inst] && dst_o[inst]) i++;
            cyc++;
        end
        @(posedge clk); #1;
        src_i[inst] = 1'b0;
        dst_i[inst] = 2'b11;
        cycles = cyc;
        chk($sformatf("pkt_done_i%0d", inst), 64'(i), 64'(n));
        $display("pkt inst=%0d words=%0d cycles=%0d", inst, n, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int e0;
        int e1;
        reset = 1'b1;
        clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din[k] = '0; src_i[k] = 1'b0; dst_i[k] = 2'b11; err_seen[k] = 0;
        end
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dst_rdy", 64'(dst_o[0]), 64'd1);
        chk("rst_src_rdy", 64'(src_o[0]), 64'd0);
        chk("rst_err", 64'(err[0]), 64'd0);
        chk("rst_drop_cnt", 64'(dcnt[0]), 64'd0);

        // 1: header to port 1, 3 payload words
        pkt[0] = mk_hdr(1, 12);
        pkt[1] = mk_word(32'hA000_0001, 1'b0);
        pkt[2] = mk_word(32'hA000_0002, 1'b0);
        pkt[3] = mk_word(32'hA000_0003, 1'b1);
        e0 = err_seen[0];
        send_pkt(0, 4, 0, 0, 1, cyc);
        idle(3);
        chk("t1_err", 64'(err_seen[0] - e0), 64'd0);
        chk("t1_sb_empty", 64'(sbq0.size()), 64'd0);

        // 2: same packet under backpressure and bursty source
        e0 = err_seen[0];
        send_pkt(0, 4, 1, 1, 1, cyc);
        idle(3);
        chk("t2_err", 64'(err_seen[0] - e0), 64'd0);
        chk("t2_sb_empty", 64'(sbq0.size()), 64'd0);

        // 3: bad port select, 5-word packet is swallowed at full rate
        pkt[0] = mk_hdr(3, 16);
        pkt[1] = mk_word(32'hB000_0001, 1'b0);
        pkt[2] = mk_word(32'hB000_0002, 1'b0);
        pkt[3] = mk_word(32'hB000_0003, 1'b0);
        pkt[4] = mk_word(32'hB000_0004, 1'b1);
        e0 = err_seen[0];
        send_pkt(0, 5, 0, 2, -1, cyc);
        idle(3);
        chk("t3_cycles", 64'(cyc), 64'd5);
        chk("t3_err", 64'(err_seen[0] - e0), 64'd1);
        chk("t3_drop_cnt", 64'(dcnt[0]), 64'd1);
        pkt[0] = mk_hdr(0, 8);
        pkt[1] = mk_word(32'hC000_0001, 1'b0);
        pkt[2] = mk_word(32'hC000_0002, 1'b1);
        send_pkt(0, 3, 0, 0, 0, cyc);
        idle(3);
        chk("t3_next_sb_empty", 64'(sbq0.size()), 64'd0);

        // 4: declared 2 words, 4 delivered
        pkt[0] = mk_hdr(1, 8);
        pkt[1] = mk_word(32'hD000_0001, 1'b0);
        pkt[2] = mk_word(32'hD000_0002, 1'b0);
        pkt[3] = mk_word(32'hD000_0003, 1'b0);
        pkt[4] = mk_word(32'hD000_0004, 1'b1);
        e0 = err_seen[0];
        send_pkt(0, 5, 0, 0, 1, cyc);
        idle(3);
        chk("t4_err", 64'(err_seen[0] - e0), 64'd1);
        chk("t4_drop_cnt", 64'(dcnt[0]), 64'd1);
        chk("t4_sb_empty", 64'(sbq0.size()), 64'd0);

        // 5: forwarding instance keeps the header word
        pkt[0] = mk_hdr(0, 8);
        pkt[1] = mk_word(32'hE000_0001, 1'b0);
        pkt[2] = mk_word(32'hE000_0002, 1'b1);
        e1 = err_seen[1];
        send_pkt(1, 3, 0, 0, 0, cyc);
        idle(3);
        chk("t5_err", 64'(err_seen[1] - e1), 64'd0);
        chk("t5_sb_empty", 64'(sbq1.size()), 64'd0);

        // 6: reset in the middle of a routed packet
        pkt[0] = mk_hdr(1, 12);
        pkt[1] = mk_word(32'hF000_0001, 1'b0);
        send_pkt(0, 2, 0, 0, 1, cyc);
        din[0]   = mk_word(32'hF000_0002, 1'b0);
        src_i[0] = 1'b1;
        dst_i[0] = 2'b01;
        @(negedge clk);
        chk("t6_route_dst_rdy", 64'(dst_o[0]), 64'd0);
        chk("t6_route_src_rdy", 64'(src_o[0]), 64'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        src_i[0] = 1'b0;
        @(negedge clk);
        chk("t6_rst_src_rdy", 64'(src_o[0]), 64'd0);
        chk("t6_rst_dst_rdy", 64'(dst_o[0]), 64'd1);
        chk("t6_rst_drop_cnt", 64'(dcnt[0]), 64'd0);
        dst_i[0] = 2'b11;
        chk("t6_sb_empty", 64'(sbq0.size()), 64'd0);

        // Single-word bad packet (EOF on header), then clear
        pkt[0] = {2'b00, 1'b1, 1'b1, 15'd2, 1'b1, 16'd0};
        e0 = err_seen[0];
        send_pkt(0, 1, 0, 0, -1, cyc);
        idle(2);
        chk("t7_err", 64'(err_seen[0] - e0), 64'd1);
        chk("t7_drop_cnt", 64'(dcnt[0]), 64'd1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        @(negedge clk);
        chk("t7_clear_drop_cnt", 64'(dcnt[0]), 64'd0);

        // Routing still works after clear
        pkt[0] = mk_hdr(1, 4);
        pkt[1] = mk_word(32'h1234_5678, 1'b1);
        e0 = err_seen[0];
        send_pkt(0, 2, 0, 0, 1, cyc);
        idle(3);
        chk("t8_err", 64'(err_seen[0] - e0), 64'd0);
        chk("t8_sb_empty", 64'(sbq0.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
